serializer_scheduler: RTL



---
 rtl/serializer_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serializer_scheduler.sv
// Round-robin scheduler sharing one serializer_in datapath between NUM_REQ requesters,
// with an inter-frame gap and EOT watchdog. Define IDLE_FILL_EN to send comma frames while idle.
module serializer_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_W     = 27,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*WORD_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      ser_start_o,
  output logic [WORD_W-1:0]         ser_data_o,
  input  logic                      ser_eot_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(NUM_REQ - 1);

`ifdef IDLE_FILL_EN
  localparam logic [WORD_W-1:0] COMMA_WORD = WORD_W'({9'h1BC, 9'h1BC, 9'h1BC});
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_EOT,
    ST_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [WORD_W-1:0]    data_q, data_d;

  logic                 found;
  logic [PTR_W-1:0]     sel;
  logic [NUM_REQ-1:0]   sel_onehot;

  // Scan offsets from the far end down so the lowest offset from the pointer wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        sel   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign sel_onehot = NUM_REQ'(1) << sel;

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    data_d      = data_q;
    req_ready_o = '0;
    err_o       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          req_ready_o = sel_onehot;
          grant_d     = sel_onehot;
          data_d      = req_data_i[int'(sel)*WORD_W +: WORD_W];
          ptr_d       = (sel == PTR_LAST) ? '0 : sel + 1'b1;
          state_d     = ST_START;
        end
`ifdef IDLE_FILL_EN
        else begin
          grant_d = '0;
          data_d  = COMMA_WORD;
          state_d = ST_START;
        end
`endif
      end

      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_EOT;
      end

      ST_WAIT_EOT: begin
        // EOT is checked first so it wins over a coincident watchdog expiry.
        if (ser_eot_i || cnt_q == TIMEOUT_LAST) begin
          err_o   = ~ser_eot_i;
          grant_d = '0;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Combinational outputs stay quiet while reset is held.
    if (!rst_ni) begin
      req_ready_o = '0;
      err_o       = 1'b0;
    end
  end

  // NOTE: state is registered with non-blocking assignments so every flop samples
  // the pre-edge values; the datapath word is reset too, since ser_data_o has a
  // defined reset value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  assign ser_start_o = (state_q == ST_START);
  assign busy_o      = (state_q != ST_IDLE);
  assign grant_o     = grant_q;
  assign ser_data_o  = data_q;

endmodule
